// File: rtl/subterranean_pkg.sv
// Shared constants, FSM encoding and lane helpers for the Subterranean duplex engine.
// Absorb/extract bit positions follow 12^(4j) mod 257 = 176^j mod 257.
package subterranean_pkg;

  localparam int SUBT_STATE_W = 257;
  localparam int SUBT_LANE_W  = 32;
  localparam int SUBT_PAD_W   = SUBT_LANE_W + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLANK = 1'b1
  } subt_fsm_e;

  function automatic int subt_pos(input int j);
    int p;
    p = 1;
    for (int i = 0; i < j; i++) p = (p * 176) % SUBT_STATE_W;
    return p;
  endfunction

  // Which padded-input bit lands on state bit b, or -1 when none does.
  function automatic int subt_absorb_idx(input int b);
    int p;
    int r;
    p = 1;
    r = -1;
    for (int j = 0; j < SUBT_PAD_W; j++) begin
      if (p == b) r = j;
      p = (p * 176) % SUBT_STATE_W;
    end
    return r;
  endfunction

  function automatic logic [SUBT_LANE_W-1:0] lane_mask(input logic [2:0] size, input logic crypt);
    logic [SUBT_LANE_W-1:0] m;
    m = 32'hFFFF_FFFF;
    if (crypt) begin
      case (size)
        3'd0:    m = 32'h0000_0000;
        3'd1:    m = 32'h0000_00FF;
        3'd2:    m = 32'h0000_FFFF;
        3'd3:    m = 32'h00FF_FFFF;
        default: m = 32'hFFFF_FFFF;
      endcase
    end
    return m;
  endfunction

  function automatic logic [SUBT_PAD_W-1:0] lane_pad(input logic [SUBT_LANE_W-1:0] word,
                                                     input logic [2:0] size);
    logic [SUBT_PAD_W-1:0] p;
    case (size)
      3'd0:    p = 33'h1;
      3'd1:    p = {24'h0, 1'b1, word[7:0]};
      3'd2:    p = {16'h0, 1'b1, word[15:0]};
      3'd3:    p = {8'h0, 1'b1, word[23:0]};
      default: p = {1'b1, word};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/subterranean_round.sv
// One Subterranean duplex round: keystream extract from the incoming state,
// then chi, iota, theta, pi and absorption of a 33-bit padded block.
module subterranean_round
  import subterranean_pkg::*;
(
  input  logic [SUBT_STATE_W-1:0] i_state,
  input  logic [SUBT_PAD_W-1:0]   i_din,
  output logic [SUBT_STATE_W-1:0] o_state,
  output logic [SUBT_LANE_W-1:0]  o_dout
);

  logic [SUBT_STATE_W-1:0] w_chi;
  logic [SUBT_STATE_W-1:0] w_theta;
  logic [SUBT_STATE_W-1:0] w_pi;

  genvar gi;
  generate
    for (gi = 0; gi < SUBT_STATE_W; gi++) begin : g_bit
      localparam int I1 = (gi + 1) % SUBT_STATE_W;
      localparam int I2 = (gi + 2) % SUBT_STATE_W;
      localparam int I3 = (gi + 3) % SUBT_STATE_W;
      localparam int I8 = (gi + 8) % SUBT_STATE_W;
      localparam int IP = (12 * gi) % SUBT_STATE_W;
      localparam int AI = subt_absorb_idx(gi);

      // iota only flips bit 0, so it is folded into chi there
      if (gi == 0) begin : g_iota
        assign w_chi[gi] = ~(i_state[gi] ^ (~i_state[I1] & i_state[I2]));
      end else begin : g_chi
        assign w_chi[gi] = i_state[gi] ^ (~i_state[I1] & i_state[I2]);
      end

      assign w_theta[gi] = w_chi[gi] ^ w_chi[I3] ^ w_chi[I8];
      assign w_pi[gi]    = w_theta[IP];

      if (AI >= 0) begin : g_abs
        assign o_state[gi] = w_pi[gi] ^ i_din[AI];
      end else begin : g_pass
        assign o_state[gi] = w_pi[gi];
      end
    end

    for (gi = 0; gi < SUBT_LANE_W; gi++) begin : g_ext
      localparam int P = subt_pos(gi);
      assign o_dout[gi] = i_state[P] ^ i_state[SUBT_STATE_W - P];
    end
  endgenerate

endmodule

// File: rtl/subterranean_rounds_param.sv
// LANES-wide Subterranean duplex engine with a blank-round sequencer and a
// back-pressurable output register; data beats and blank runs share one round chain.
module subterranean_rounds_param
  import subterranean_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  encrypt,
  input  logic                  decrypt,
  input  logic                  blank_start,
  input  logic [3:0]            blank_rounds,
  input  logic [LW-1:0]         enable_round,
  input  logic [32*LANES-1:0]   din,
  input  logic [3*LANES-1:0]    din_size,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [32*LANES-1:0]   dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  free,
  output logic                  finish
);

  localparam int CW = 5;

  subt_fsm_e               r_fsm;
  subt_fsm_e               w_fsm_next;
  logic [SUBT_STATE_W-1:0] r_state;
  logic [SUBT_STATE_W-1:0] w_state_next;
  logic [3:0]              r_counter;
  logic [3:0]              w_counter_next;
  logic [32*LANES-1:0]     r_dout;
  logic [32*LANES-1:0]     w_dout_next;
  logic                    r_dout_valid;
  logic                    w_dout_valid_next;
  logic                    r_finish;
  logic                    w_finish_next;

  logic                    w_blank;
  logic                    w_crypt;
  logic                    w_accept;
  logic [CW-1:0]           w_beat_m;
  logic [CW-1:0]           w_blank_n;
  logic [CW-1:0]           w_tap;
  logic [SUBT_STATE_W-1:0] w_tap_state;
  logic [32*LANES-1:0]     w_beat_dout;

  assign w_blank   = (r_fsm == ST_BLANK);
  assign w_crypt   = encrypt | decrypt;
  assign w_beat_m  = {{(CW-LW){1'b0}}, enable_round} + CW'(1);
  assign w_blank_n = ({1'b0, r_counter} > CW'(LANES)) ? CW'(LANES) : {1'b0, r_counter};
  assign w_tap     = w_blank ? w_blank_n : w_beat_m;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [2:0]              w_size;
      logic [SUBT_LANE_W-1:0]  w_din_k;
      logic [SUBT_LANE_W-1:0]  w_ks;
      logic [SUBT_LANE_W-1:0]  w_x;
      logic [SUBT_LANE_W-1:0]  w_word;
      logic [SUBT_PAD_W-1:0]   w_pad;
      logic [SUBT_STATE_W-1:0] w_state_in;
      logic [SUBT_STATE_W-1:0] w_state_out;
      logic [SUBT_STATE_W-1:0] w_pick;

      assign w_size  = din_size[3*gi +: 3];
      assign w_din_k = din[32*gi +: 32];
      assign w_x     = (w_ks & lane_mask(w_size, w_crypt)) ^ w_din_k;
      assign w_word  = decrypt ? w_x : w_din_k;
      // blank rounds absorb the empty block
      assign w_pad   = w_blank ? 33'h1 : lane_pad(w_word, w_size);
      assign w_beat_dout[32*gi +: 32] = (CW'(gi) < w_beat_m) ? w_x : '0;

      // w_pick accumulates the state after round number w_tap along the chain
      if (gi == 0) begin : g_head
        assign w_state_in = r_state;
        assign w_pick     = (w_tap == CW'(1)) ? w_state_out : '0;
      end else begin : g_link
        assign w_state_in = g_lane[gi-1].w_state_out;
        assign w_pick     = g_lane[gi-1].w_pick |
                            ((w_tap == CW'(gi + 1)) ? w_state_out : '0);
      end

      subterranean_round u_round (
        .i_state (w_state_in),
        .i_din   (w_pad),
        .o_state (w_state_out),
        .o_dout  (w_ks)
      );
    end
  endgenerate

  assign w_tap_state = g_lane[LANES-1].w_pick;

  assign din_ready = (r_fsm == ST_IDLE) & ~init & ~blank_start & (~r_dout_valid | dout_ready);
  assign w_accept  = din_valid & din_ready;

  always_comb begin
    w_fsm_next        = r_fsm;
    w_state_next      = r_state;
    w_counter_next    = r_counter;
    w_dout_next       = r_dout;
    w_dout_valid_next = r_dout_valid & ~dout_ready;
    w_finish_next     = 1'b0;
    unique case (r_fsm)
      ST_IDLE: begin
        if (init) begin
          w_state_next  = '0;
          w_finish_next = 1'b1;
        end else if (blank_start) begin
          if (blank_rounds == 4'd0) begin
            w_finish_next = 1'b1;
          end else begin
            w_counter_next = blank_rounds;
            w_fsm_next     = ST_BLANK;
          end
        end else if (w_accept) begin
          w_state_next      = w_tap_state;
          w_dout_next       = w_beat_dout;
          w_dout_valid_next = 1'b1;
          w_finish_next     = 1'b1;
        end
      end
      ST_BLANK: begin
        if (init) begin
          w_state_next   = '0;
          w_counter_next = 4'd0;
          w_fsm_next     = ST_IDLE;
          w_finish_next  = 1'b1;
        end else begin
          w_state_next   = w_tap_state;
          w_counter_next = r_counter - w_blank_n[3:0];
          if (r_counter == w_blank_n[3:0]) begin
            w_fsm_next    = ST_IDLE;
            w_finish_next = 1'b1;
          end
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm        <= ST_IDLE;
      r_state      <= '0;
      r_counter    <= 4'd0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_finish     <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_next;
      r_state      <= w_state_next;
      r_counter    <= w_counter_next;
      r_dout       <= w_dout_next;
      r_dout_valid <= w_dout_valid_next;
      r_finish     <= w_finish_next;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign free       = (r_fsm == ST_IDLE);
  assign finish     = r_finish;

endmodule

// File: tb/tb_subterranean_rounds_param.sv
// Directed bench for subterranean_rounds_param (LANES=4) with a bit-level
// reference model of the duplex and a dout scoreboard.
module tb_subterranean_rounds_param;

  localparam int LANES = 4;
  localparam int LW    = 2;
  localparam int DW    = 32 * LANES;

  logic               clk = 1'b0;
  logic               rst;
  logic               init;
  logic               encrypt;
  logic               decrypt;
  logic               blank_start;
  logic [3:0]         blank_rounds;
  logic [LW-1:0]      enable_round;
  logic [DW-1:0]      din;
  logic [3*LANES-1:0] din_size;
  logic               din_valid;
  logic               din_ready;
  logic [DW-1:0]      dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               free;
  logic               finish;

  always #5 clk = ~clk;

  subterranean_rounds_param #(.LANES(LANES), .LW(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .init         (init),
    .encrypt      (encrypt),
    .decrypt      (decrypt),
    .blank_start  (blank_start),
    .blank_rounds (blank_rounds),
    .enable_round (enable_round),
    .din          (din),
    .din_size     (din_size),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .free         (free),
    .finish       (finish)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            n_txn = 0;
  logic [256:0]  m_state;
  logic [DW-1:0] sb_q[$];
  logic [31:0]   ks0;
  logic [31:0]   dec_exp;

  // Reference duplex round, written straight from the algorithm definition.
  function automatic logic [256:0] m_round(input logic [256:0] s, input logic [32:0] sig);
    logic [256:0] a;
    logic [256:0] t;
    int p;
    for (int i = 0; i < 257; i++) a[i] = s[i] ^ ((~s[(i + 1) % 257]) & s[(i + 2) % 257]);
    a[0] = ~a[0];
    for (int i = 0; i < 257; i++) t[i] = a[i] ^ a[(i + 3) % 257] ^ a[(i + 8) % 257];
    for (int i = 0; i < 257; i++) a[i] = t[(12 * i) % 257];
    p = 1;
    for (int j = 0; j < 33; j++) begin
      a[p] = a[p] ^ sig[j];
      p = (p * 20736) % 257;
    end
    return a;
  endfunction

  function automatic logic [31:0] m_extract(input logic [256:0] s);
    logic [31:0] z;
    int p;
    p = 1;
    for (int i = 0; i < 32; i++) begin
      z[i] = s[p] ^ s[257 - p];
      p = (p * 20736) % 257;
    end
    return z;
  endfunction

  function automatic logic [32:0] m_pad(input logic [31:0] w, input logic [2:0] sz);
    logic [32:0] p;
    int n;
    n = (sz > 3'd4) ? 4 : int'(sz);
    p = '0;
    for (int b = 0; b < 8 * n; b++) p[b] = w[b];
    p[8 * n] = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] m_mask(input logic [2:0] sz, input logic crypt);
    if (!crypt || sz >= 3'd4) return 32'hFFFF_FFFF;
    return (32'h1 << (8 * int'(sz))) - 32'h1;
  endfunction

  task automatic model_beat(output logic [DW-1:0] e);
    logic [31:0] ks, x, dk, w;
    logic [2:0]  sz;
    int          m;
    e = '0;
    m = int'(enable_round) + 1;
    for (int k = 0; k < m; k++) begin
      dk = din[32*k +: 32];
      sz = din_size[3*k +: 3];
      ks = m_extract(m_state);
      x  = (ks & m_mask(sz, encrypt | decrypt)) ^ dk;
      w  = decrypt ? x : dk;
      e[32*k +: 32] = x;
      m_state = m_round(m_state, m_pad(w, sz));
    end
  endtask

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drain/compare the output register, record an accepted beat, advance.
  task automatic cyc();
    logic [DW-1:0] e;
    #1;
    if (dout_valid && dout_ready) begin
      chk("sb_pending", sb_q.size() != 0, 1'b1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("dout", dout, e);
        $display("txn %0d: dout=%h", n_txn, dout);
        n_txn++;
      end
    end
    if (din_valid && din_ready) begin
      model_beat(e);
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic blank_run(input int r, input string tag);
    int cycles;
    blank_start  = 1'b1;
    blank_rounds = 4'(r);
    #1 chk({tag, "_rdy_blocked"}, din_ready, 1'b0);
    cyc();
    blank_start = 1'b0;
    for (int i = 0; i < r; i++) m_state = m_round(m_state, 33'h1);
    cycles = 0;
    while (!free && cycles < 20) begin
      chk({tag, "_busy_finish"}, finish, 1'b0);
      cyc();
      cycles++;
    end
    chk({tag, "_busy_cycles"}, cycles, (r + LANES - 1) / LANES);
    chk({tag, "_finish"}, finish, 1'b1);
    chk({tag, "_state"}, dut.r_state, m_state);
    cyc();
    chk({tag, "_finish_clr"}, finish, 1'b0);
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [3*LANES-1:0] sz, input int er,
                      input logic enc, input logic dec, input string tag);
    din          = d;
    din_size     = sz;
    enable_round = LW'(er);
    encrypt      = enc;
    decrypt      = dec;
    din_valid    = 1'b1;
    #1 chk({tag, "_rdy"}, din_ready, 1'b1);
    cyc();
    din_valid = 1'b0;
    encrypt   = 1'b0;
    decrypt   = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init = 1'b0; encrypt = 1'b0; decrypt = 1'b0;
    blank_start = 1'b0; blank_rounds = 4'd0; enable_round = '0;
    din = '0; din_size = '0; din_valid = 1'b0; dout_ready = 1'b1;
    m_state = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_free", free, 1'b1);
    chk("rst_dout_valid", dout_valid, 1'b0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_dout", dout, '0);
    chk("rst_state", dut.r_state, '0);
    #1 chk("rst_din_ready", din_ready, 1'b1);

    // blank runs: 8 -> 2 cycles, 5 -> 2 cycles, 0 -> none
    blank_run(8, "blank8");
    blank_run(5, "blank5");
    blank_run(0, "blank0");

    // encrypt beat, all lanes full
    beat(rnd(), {LANES{3'd4}}, 3, 1'b1, 1'b0, "enc4");
    chk("enc4_valid", dout_valid, 1'b1);
    chk("enc4_finish", finish, 1'b1);
    chk("enc4_state", dut.r_state, m_state);
    cyc();
    chk("enc4_finish_clr", finish, 1'b0);

    // decrypt beat, lane 0 only, two bytes
    ks0     = m_extract(m_state);
    dec_exp = 32'hAABB_0000 | ((ks0 & 32'h0000_FFFF) ^ 32'h0000_CCDD);
    beat({rnd() >> 32, 32'hAABB_CCDD}, {3'd4, 3'd4, 3'd4, 3'd2}, 0, 1'b0, 1'b1, "dec2");
    chk("dec2_lane0", dout[31:0], dec_exp);
    chk("dec2_upper_zero", dout[DW-1:32], '0);
    chk("dec2_state", dut.r_state, m_round(m_state, 33'h0_0000_0000) ^ m_round(m_state, 33'h0_0000_0000) ^ m_state);
    cyc();

    // mixed sizes, encrypt on two lanes; plain on three lanes; enc+dec on four
    beat(rnd(), {3'd0, 3'd3, 3'd1, 3'd2}, 1, 1'b1, 1'b0, "enc_mix");
    beat(rnd(), {3'd2, 3'd0, 3'd3, 3'd1}, 2, 1'b0, 1'b0, "plain_mix");
    beat(rnd(), {3'd1, 3'd4, 3'd0, 3'd3}, 3, 1'b1, 1'b1, "encdec");
    cyc();
    chk("mix_state", dut.r_state, m_state);

    // back-pressure: one result held for 3 cycles, then back-to-back beats
    dout_ready = 1'b0;
    beat(rnd(), {LANES{3'd4}}, 3, 1'b1, 1'b0, "bp_a");
    din = rnd(); din_size = {LANES{3'd3}}; enable_round = 2'd3; encrypt = 1'b1; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_din_ready", din_ready, 1'b0);
      chk("bp_valid", dout_valid, 1'b1);
      chk("bp_dout_hold", dout, sb_q[0]);
      cyc();
    end
    dout_ready = 1'b1;
    #1 chk("bp_release_rdy", din_ready, 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) begin
      din = rnd();
      #1 chk("b2b_rdy", din_ready, 1'b1);
      chk("b2b_valid", dout_valid, 1'b1);
      cyc();
    end
    din_valid = 1'b0; encrypt = 1'b0;
    cyc();
    chk("b2b_state", dut.r_state, m_state);
    chk("b2b_drained", dout_valid, 1'b0);

    // init aborts a 12-round blank run in its second cycle
    blank_start = 1'b1; blank_rounds = 4'd12;
    cyc();
    blank_start = 1'b0;
    chk("abort_busy1", free, 1'b0);
    cyc();
    chk("abort_busy2", free, 1'b0);
    init = 1'b1;
    cyc();
    init = 1'b0;
    m_state = '0;
    chk("abort_free", free, 1'b1);
    chk("abort_finish", finish, 1'b1);
    chk("abort_state", dut.r_state, '0);
    cyc();

    // init beats blank_start; a pending result survives init
    beat(rnd(), {LANES{3'd4}}, 3, 1'b0, 1'b0, "pre_init");
    dout_ready = 1'b0;
    init = 1'b1; blank_start = 1'b1; blank_rounds = 4'd5;
    #1 chk("initwin_rdy", din_ready, 1'b0);
    cyc();
    init = 1'b0; blank_start = 1'b0;
    m_state = '0;
    chk("initwin_free", free, 1'b1);
    chk("initwin_finish", finish, 1'b1);
    chk("initwin_state", dut.r_state, '0);
    chk("initwin_pending", dout_valid, 1'b1);
    cyc();
    chk("initwin_still_idle", free, 1'b1);
    dout_ready = 1'b1;
    cyc();

    // reset with a pending result discards it
    dout_ready = 1'b0;
    beat(rnd(), {LANES{3'd4}}, 3, 1'b1, 1'b0, "pre_rst");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    sb_q.delete();
    m_state = '0;
    chk("rst2_valid", dout_valid, 1'b0);
    chk("rst2_dout", dout, '0);
    chk("rst2_state", dut.r_state, '0);
    dout_ready = 1'b1;

    beat(rnd(), {LANES{3'd4}}, 3, 1'b1, 1'b0, "post_rst");
    cyc();
    chk("post_rst_state", dut.r_state, m_state);
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
